// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the fetch PC for a 4-wide front end, picks how many
// instructions to fetch each cycle and allocates matching contiguous ROB
// entries, with support for branch redirects, ROB flushes and halt.
module fetch_sequencer #(
   parameter logic [15:0] RESET_PC  = 16'h0000,
   parameter int unsigned ROB_DEPTH = 16,
   parameter int unsigned FETCH_W   = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] jump_target,
   input  logic        is_jump,
   input  logic        rob_flush,
   input  logic [2:0]  commit_count,
   input  logic [3:0]  ibuf_free,
   input  logic        halt_req,
   output logic [63:0] pc_to_icache,
   output logic [3:0]  fetch_valid,
   output logic [2:0]  fetch_count,
   output logic [3:0]  dec_valid,
   output logic [3:0]  dec_rob_base,
   output logic [3:0]  rob_head_idx,
   output logic [3:0]  rob_tail_idx,
   output logic [4:0]  rob_occupancy,
   output logic        halted
);

   typedef enum logic [1:0] {
      ST_START,
      ST_FETCH,
      ST_REDIRECT,
      ST_HALTED
   } state_t;

   state_t      state;
   state_t      state_nx;

   logic [15:0] pc;
   logic [3:0]  head;
   logic [3:0]  tail;
   logic [4:0]  occ;

   logic [4:0]  rob_free;
   logic [4:0]  lim;
   logic [2:0]  fc;
   logic [2:0]  eff_commit;
   logic [3:0]  head_nx;
   logic        fetch_ok;

   // Fetch group size: bounded by fetch width, ibuf space and ROB space.
   always_comb begin
      rob_free = 5'(ROB_DEPTH) - occ;
      lim      = 5'(FETCH_W);
      if ({1'b0, ibuf_free} < lim) lim = {1'b0, ibuf_free};
      if (rob_free < lim) lim = rob_free;
      fetch_ok = (state == ST_FETCH) && !is_jump && !rob_flush && !halt_req;
      fc       = fetch_ok ? lim[2:0] : 3'd0;
   end

   // Thermometer lane mask from the group size.
   always_comb begin
      case (fc)
         3'd0:    fetch_valid = 4'b0000;
         3'd1:    fetch_valid = 4'b0001;
         3'd2:    fetch_valid = 4'b0011;
         3'd3:    fetch_valid = 4'b0111;
         default: fetch_valid = 4'b1111;
      endcase
   end

   // Retire no more entries than are actually allocated.
   always_comb begin
      if ({2'b00, commit_count} < occ) eff_commit = commit_count;
      else                             eff_commit = occ[2:0];
      head_nx = head + {1'b0, eff_commit};
   end

   // Per-lane PCs, always driven with 16-bit wrap.
   always_comb begin
      pc_to_icache = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         pc_to_icache[16*i +: 16] = pc + 16'(2*i);
      end
   end

   // Next-state: halt wins over redirect; HALTED is left only by reset.
   always_comb begin
      state_nx = state;
      case (state)
         ST_START:    state_nx = ST_FETCH;
         ST_FETCH:    state_nx = ST_FETCH;
         ST_REDIRECT: state_nx = ST_FETCH;
         ST_HALTED:   state_nx = ST_HALTED;
         default:     state_nx = ST_START;
      endcase
      if (state != ST_HALTED && is_jump) state_nx = ST_REDIRECT;
      if (halt_req)                      state_nx = ST_HALTED;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= ST_START;
      else     state <= state_nx;
   end

   // PC, ROB pointers and decode-stage alignment registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc           <= RESET_PC;
         head         <= '0;
         tail         <= '0;
         occ          <= '0;
         dec_valid    <= '0;
         dec_rob_base <= '0;
      end else begin
         if (is_jump) pc <= jump_target;
         else         pc <= pc + {12'd0, fc, 1'b0};

         head         <= head_nx;
         dec_rob_base <= tail;

         // A flush retires this cycle's commits first, then empties the ROB
         // so the tail restarts at the post-commit head.
         if (rob_flush) begin
            tail <= head_nx;
            occ  <= '0;
         end else begin
            tail <= tail + {1'b0, fc};
            occ  <= occ + {2'b00, fc} - {2'b00, eff_commit};
         end

         if (is_jump || rob_flush) dec_valid <= '0;
         else                      dec_valid <= fetch_valid;
      end
   end

   assign fetch_count   = fc;
   assign rob_head_idx  = head;
   assign rob_tail_idx  = tail;
   assign rob_occupancy = occ;
   assign halted        = (state == ST_HALTED);

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Sequences the 4-wide front end.
- Owns the architectural fetch PC and decides each cycle how many instructions (0-4) to fetch from the icache.
- Allocates the matching contiguous ROB entries, tracking ROB head, tail and occupancy.
- Handles branch redirects, ROB flushes and halt. Sits between the branch unit, instruction buffer and ROB on one side, and the icache and fetch/decode stage on the other.

Parameters:
- RESET_PC, 16'h0000, PC loaded on reset.
- ROB_DEPTH, 16, ROB entries. Fixed power of two; indices are 4 bits.
- FETCH_W, 4, maximum instructions per group.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- jump_target  in  16  redirect PC from branch unit
- is_jump  in  1  redirect request, sampled at posedge
- rob_flush  in  1  discard all uncommitted ROB entries
- commit_count  in  3  ROB entries retired this cycle (0-4)
- ibuf_free  in  4  free instruction-buffer slots (0-15)
- halt_req  in  1  stop fetching permanently until reset
- pc_to_icache  out  64  lane i = bits [16i+15:16i]; lane i = pc + 2*i
- fetch_valid  out  4  thermometer mask of lanes fetched this cycle
- fetch_count  out  3  number of set bits in fetch_valid
- dec_valid  out  4  fetch_valid delayed one cycle, aligned with icache data
- dec_rob_base  out  4  ROB index of dec lane 0; lane i owns dec_rob_base+i mod 16
- rob_head_idx  out  4  oldest uncommitted ROB entry
- rob_tail_idx  out  4  next ROB entry to allocate
- rob_occupancy  out  5  allocated entries (0-16)
- halted  out  1  high in HALTED state

Behaviour:
- Reset (rst high at posedge):
  - pc=RESET_PC; head=tail=0; occupancy=0; dec_valid=0; dec_rob_base=0.
  - State=START; all outputs are derived from these values.
  - rst dominates every other input, including mid-redirect and while HALTED.
- States:
  - START: one cycle after reset, fetch_valid=0, then FETCH.
  - FETCH: normal operation.
  - REDIRECT: one bubble cycle, fetch_valid=0, then FETCH.
  - HALTED: absorbing; only rst leaves it.
- Fetch count, combinational:
  - rob_free = 16 - occupancy.
  - fetch_count = min(4, ibuf_free, rob_free) in FETCH; 0 in any other state.
  - fetch_count is also forced to 0 in any cycle where is_jump, rob_flush or halt_req is high.
  - fetch_valid = (1<<fetch_count)-1.
- pc_to_icache lanes are always driven as pc+2i, with 16-bit wrap (e.g. pc=16'hFFFE gives lane1=16'h0000). Lanes not flagged in fetch_valid are don't-care to consumers.
- Posedge update, no redirect:
  - pc += 2*fetch_count.
  - tail += fetch_count (mod 16).
  - head += eff_commit (mod 16), where eff_commit = min(commit_count, occupancy).
  - occupancy += fetch_count - eff_commit.
  - dec_valid <= fetch_valid; dec_rob_base <= old tail.
- is_jump at posedge:
  - pc <= jump_target; state <= REDIRECT; dec_valid <= 0.
  - ROB is untouched unless rob_flush is also high.
- rob_flush at posedge:
  - head advances by eff_commit first, then tail <= new head and occupancy <= 0.
  - dec_valid <= 0.
  - State is unchanged unless is_jump is also high; in the normal case both assert together.
- halt_req at posedge: state <= HALTED. halt_req has priority over is_jump in the state transition, but a jump_target is still loaded into pc.
- HALTED: no allocation; commits and flushes are still processed so the ROB drains.
- Boundaries:
  - occupancy=16 (full) → fetch_count=0.
  - ibuf_free=0 → fetch_count=0.
  - Commit and allocate in the same cycle are both applied.
  - Index wrap: tail=14, count 4 gives tail 2.

Test Plan:
- Reset, then ibuf_free=15, no commits. Required: START cycle has mask 0; next cycle pc=0, mask 4'b1111. Next cycle pc=8, dec_valid=4'b1111, dec_rob_base=0, tail=4, occupancy=4.
- Fill ROB with no commits, ibuf_free=15. Required: groups of 4 until occupancy=16, then fetch_count=0 and pc frozen at 16'h0020. Then commit_count=2: next cycle fetch_count=2.
- ibuf_free=3, occupancy=0, pc=16'h0010. Required: mask 4'b0111; next pc=16'h0016, tail advances by 3.
- is_jump=1, jump_target=16'h0100 while fetching. Required: that cycle fetch_valid=0; next cycle REDIRECT with mask 0 and dec_valid=0. Following cycle pc lanes are 0100/0102/0104/0106.
- head=3, occupancy=7, rob_flush=1 with commit_count=2. Required: head=5, tail=5, occupancy=0, dec_valid=0.
- halt_req=1 with occupancy=4. Required: halted=1, fetch_valid stays 0. commit_count=4 then gives occupancy=0. rst=1 returns pc to RESET_PC and halted to 0.
